// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit -- iterative RV32M multiply/divide unit.
//
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// clock over XLEN iterations. Operands are reduced to magnitudes on entry,
// and the sign is re-applied in a single fix-up cycle. Divide-by-zero and
// signed overflow bypass the iteration and complete in one cycle.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   request, sampled only while idle
//   abort   in   cancel an operation in CALC/FIX
//   op      in   RV32M funct3 (MUL..REMU)
//   a, b    in   rs1 / rs2 operands, sampled with start
//   busy    out  high whenever not idle
//   done    out  one-cycle pulse, result valid
//   result  out  registered result, held until overwritten
module riscv_muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   md_q;      // multiplicand / divisor magnitude
    logic [XLEN-1:0]   hi_q;      // product high word / partial remainder
    logic [XLEN-1:0]   lo_q;      // multiplier->product low / dividend->quotient
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  cnt_q;

    // Input decode, used only on the accepting edge
    logic              a_sgn, b_sgn, div_zero, div_ovf, special;
    logic [XLEN-1:0]   abs_a, abs_b, special_res;

    always_comb begin
        a_sgn    = a[XLEN-1] & ((op == 3'b001) | (op == 3'b010) |
                                (op == 3'b100) | (op == 3'b110));
        b_sgn    = b[XLEN-1] & ((op == 3'b001) | (op == 3'b100) | (op == 3'b110));
        abs_a    = a_sgn ? -a : a;
        abs_b    = b_sgn ? -b : b;
        div_zero = op[2] & (b == '0);
        div_ovf  = op[2] & ~op[0] & (a == XMIN) & (b == '1);
        special  = div_zero | div_ovf;
        if (div_zero) special_res = op[1] ? a : '1;
        else          special_res = op[1] ? '0 : XMIN;
    end

    // One iteration step
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_d, lo_d;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? md_q : '0)};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, md_q};
        if (op_q[2]) begin
            // Borrow out of the top bit means the trial subtract failed
            if (!div_diff[XLEN]) begin
                hi_d = div_diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and word selection
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fix_res;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        q_fix    = neg_q ? -lo_q : lo_q;
        r_fix    = neg_q ? -hi_q : hi_q;
        if (op_q[2])                 fix_res = op_q[1] ? r_fix : q_fix;
        else if (op_q[1:0] == 2'b00) fix_res = prod_fix[XLEN-1:0];
        else                         fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = special ? DONE : CALC;
            CALC: begin
                if (abort)                                state_d = IDLE;
                else if (cnt_q == CNT_W'(XLEN - 1))       state_d = FIX;
            end
            FIX:  state_d = abort ? IDLE : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        result = result_q;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            md_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_q  <= op;
                    // Remainder takes the dividend's sign; all else the XOR
                    neg_q <= (op[2] & op[1]) ? a_sgn : (a_sgn ^ b_sgn);
                    cnt_q <= '0;
                    hi_q  <= '0;
                    if (op[2]) begin
                        lo_q <= abs_a;
                        md_q <= abs_b;
                    end else begin
                        lo_q <= abs_b;
                        md_q <= abs_a;
                    end
                    if (special) result_q <= special_res;
                end
                CALC: if (!abort) begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: if (!abort) result_q <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
module tb_riscv_muldiv_unit;

    localparam int XLEN = 32;
    localparam int NLAT = XLEN + 1;   // done offset (cycles after E0) for normal ops
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    // Reference model built on 64-bit native arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, ps;
        logic [63:0] ux, uy, pu;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (f)
            3'd0: begin pu = ux * uy; return pu[31:0]; end
            3'd1: begin ps = sx * sy; return ps[63:32]; end
            3'd2: begin ps = sx * $signed(uy); return ps[63:32]; end
            3'd3: begin pu = ux * uy; return pu[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN && y == 32'hFFFF_FFFF) return MIN;
                ps = sx / sy; return ps[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN && y == 32'hFFFF_FFFF) return 32'h0;
                ps = sx % sy; return ps[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && ((y == 0) || (!f[0] && x == MIN && y == 32'hFFFF_FFFF));
    endfunction

    // Drive one request; returns at the negedge following E0 with inputs scrambled
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input bit push);
        @(negedge clk);
        op = f; a = x; b = y; start = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    // Wait (bounded) for done; report observations, pop expected from the scoreboard
    task automatic collect(output logic [31:0] got, output logic [31:0] ev, output int lat,
                           output int bc, output bit to, output logic done_after, output logic busy_after);
        lat = 0; bc = 0; to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) begin lat = k; to = 1'b0; break; end
            @(negedge clk);
        end
        got = result;
        ev  = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors(input string name, input vec_t v[$]);
        logic [31:0] got, ev; int lat, bc; bit to; logic da, ba;
        foreach (v[i]) begin
            issue(v[i].f, v[i].x, v[i].y, v[i].e, 1'b1);
            collect(got, ev, lat, bc, to, da, ba);
            tests++;
            if (to || got !== ev) begin
                fails++;
                $display("FAIL %s[%0d] op=%0d a=%h b=%h: result %h, required %h (timeout=%0b)",
                         name, i, v[i].f, v[i].x, v[i].y, got, ev, to);
            end
            tests++;
            if (lat !== v[i].lat || bc !== v[i].lat + 1) begin
                fails++;
                $display("FAIL %s[%0d] timing: done offset %0d busy cycles %0d, required %0d and %0d",
                         name, i, lat, bc, v[i].lat, v[i].lat + 1);
            end
            tests++;
            if (da !== 1'b0 || ba !== 1'b0) begin
                fails++;
                $display("FAIL %s[%0d] pulse: done=%b busy=%b after done cycle, required 0 0", name, i, da, ba);
            end
        end
    endtask

    task automatic test_mul;
        vec_t v[$];
        v.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, NLAT});
        v.push_back('{3'd1, MIN,            MIN,           32'h4000_0000, NLAT});
        v.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, NLAT});
        v.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, NLAT});
        test_vectors("mul", v);
    endtask

    task automatic test_div;
        vec_t v[$];
        v.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NLAT});
        v.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NLAT});
        v.push_back('{3'd5, 32'd100,       32'd7, 32'd14,        NLAT});
        v.push_back('{3'd7, 32'd100,       32'd7, 32'd2,         NLAT});
        test_vectors("div", v);
    endtask

    task automatic test_div_special;
        vec_t v[$];
        v.push_back('{3'd5, 32'd5, 32'd0,          32'hFFFF_FFFF, 0});
        v.push_back('{3'd7, 32'd5, 32'd0,          32'd5,         0});
        v.push_back('{3'd4, MIN,   32'hFFFF_FFFF,  MIN,           0});
        v.push_back('{3'd6, MIN,   32'hFFFF_FFFF,  32'd0,         0});
        test_vectors("divspecial", v);
    endtask

    task automatic test_random;
        vec_t v[$];
        logic [2:0] f; logic [31:0] x, y;
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: x = 32'h0; 1: x = MIN; 2: x = 32'hFFFF_FFFF; default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: y = 32'h0; 1: y = MIN; 2: y = 32'hFFFF_FFFF; default: y = $urandom;
            endcase
            v.push_back('{f, x, y, model(f, x, y), is_special(f, x, y) ? 0 : NLAT});
        end
        test_vectors("random", v);
    endtask

    // Second start mid-operation is ignored; operands/op changing after E0 too
    task automatic test_busy_ignore;
        logic [31:0] got, ev; int lat, bc; bit to; logic da, ba;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        collect(got, ev, lat, bc, to, da, ba);
        tests++;
        if (to || got !== ev || lat !== NLAT - 5) begin
            fails++;
            $display("FAIL busy_ignore: result %h offset %0d, required %h offset %0d", got, lat, ev, NLAT - 5);
        end
    endtask

    // start and abort during the DONE cycle are both ignored
    task automatic test_done_cycle;
        logic [31:0] ev;
        issue(3'd7, 32'd5, 32'd0, 32'd5, 1'b1);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL done_cycle pulse: done=%b, required 1", done);
        end
        ev = exp_q.pop_front();
        tests++;
        if (result !== ev) begin
            fails++;
            $display("FAIL done_cycle result: %h, required %h", result, ev);
        end
        start = 1'b1; abort = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== ev) begin
            fails++;
            $display("FAIL done_cycle ignore: busy=%b done=%b result=%h, required 0 0 %h", busy, done, result, ev);
        end
    endtask

    task automatic test_abort;
        logic [31:0] got, ev; int lat, bc; bit to; logic da, ba; int seen;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        collect(got, ev, lat, bc, to, da, ba);
        tests++;
        if (to || got !== ev) begin
            fails++;
            $display("FAIL abort_setup: result %h, required %h", got, ev);
        end
        // abort in CALC at E0+10
        issue(3'd0, 32'd3, 32'd5, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL abort_calc: busy=%b done=%b result=%h, required 0 0 fffffffe", busy, done, result);
        end
        seen = 0;
        repeat (40) begin @(negedge clk); if (done !== 1'b0) seen++; end
        tests++;
        if (seen != 0 || result !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL abort_calc_quiet: done cycles %0d result %h, required 0 fffffffe", seen, result);
        end
        // abort in FIX (cycle after E0+32)
        issue(3'd0, 32'd3, 32'd5, 32'd0, 1'b0);
        repeat (32) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        seen = 0;
        repeat (5) begin if (done !== 1'b0) seen++; @(negedge clk); end
        tests++;
        if (busy !== 1'b0 || seen != 0 || result !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL abort_fix: busy=%b done cycles %0d result=%h, required 0 0 fffffffe", busy, seen, result);
        end
        // abort while idle does nothing; start+abort together: start wins
        abort = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || result !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL abort_idle: busy=%b result=%h, required 0 fffffffe", busy, result);
        end
        op = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
        exp_q.push_back(32'd15);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        collect(got, ev, lat, bc, to, da, ba);
        tests++;
        if (to || got !== ev || lat !== NLAT) begin
            fails++;
            $display("FAIL start_wins: result %h offset %0d, required %h offset %0d", got, lat, ev, NLAT);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] got, ev; int lat, bc; bit to; logic da, ba;
        issue(3'd0, 32'd9, 32'd9, 32'd0, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(3'd0, 32'd3, 32'd4, 32'd12, 1'b1);
        collect(got, ev, lat, bc, to, da, ba);
        tests++;
        if (to || got !== ev || lat !== NLAT || bc !== NLAT + 1) begin
            fails++;
            $display("FAIL reset_then_mul: result %h offset %0d busy %0d, required %h %0d %0d",
                     got, lat, bc, ev, NLAT, NLAT + 1);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_busy_ignore();
        test_done_cycle();
        test_abort();
        test_reset_mid();
        test_random();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_muldiv_unit.md
RISCV_MULDIV_UNIT -- requirements
Module: riscv_muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width in bits (SHALL support any even value >= 8).
REQ-002 Parameter: CNT_W, default $clog2(XLEN)+1, width of the iteration counter.
REQ-003 Port: clk  input  1  clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  request, sampled only while busy=0.
REQ-006 Port: abort  input  1  synchronous cancel of an operation in flight.
REQ-007 Port: op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port: a  input  XLEN  rs1 operand, sampled with start.
REQ-009 Port: b  input  XLEN  rs2 operand, sampled with start.
REQ-010 Port: busy  output  1  high whenever state != IDLE.
REQ-011 Port: done  output  1  one-cycle pulse, result valid.
REQ-012 Port: result  output  XLEN  registered result, held until next accepted start.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 IDLE: start=1 at edge E0 SHALL latch op/a/b, take operand magnitudes for signed ops, clear the counter, and go to CALC.
REQ-015 CALC SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) iteration per edge, XLEN iterations, then go to FIX at edge E0+XLEN.
REQ-016 FIX SHALL apply sign correction, select the low/high product word or the quotient/remainder, register result, and go to DONE at edge E0+XLEN+1.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE on the next edge.
REQ-018 Normal-case done SHALL be high in the cycle following edge E0+XLEN+1.
REQ-019 The multiply sign rules SHALL be: MULH signed x signed; MULHSU signed a x unsigned b; MULHU unsigned x unsigned; MUL returns the low XLEN bits.
REQ-020 Division SHALL truncate toward zero, and the remainder sign SHALL equal the sign of a.
REQ-021 Divide by zero (b=0) SHALL go IDLE->DONE at E0, with DIV/DIVU = all ones and REM/REMU = a.
REQ-022 Signed overflow (DIV/REM, a = MIN, b = -1) SHALL go IDLE->DONE at E0, with DIV = MIN and REM = 0.
REQ-023 start while busy=1, including the DONE cycle, SHALL be ignored; latched operands SHALL be unaffected.
REQ-024 abort=1 in CALC or FIX SHALL return to IDLE at the next edge with no done pulse and result unchanged; abort SHALL have no effect in IDLE or DONE.
REQ-025 If start and abort are both high in IDLE, start SHALL win.
REQ-026 Input changes on a and b after E0 SHALL NOT affect the result.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, result=0, counter=0 and internal datapath registers to 0, including mid-operation.
REQ-028 The first start after rst deasserts SHALL behave exactly like any other start.

Verification (XLEN=32)
REQ-029 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done high exactly in the cycle after E0+33; busy high for 34 cycles.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; each with done in the cycle after E0.
REQ-033 A second start with different operands at E0+5 SHALL be ignored and the first result delivered; abort at E0+10 -> busy=0 after the next edge, no done, result keeps its prior value.
REQ-034 rst pulse at E0+20 -> busy=0, done=0, result=0 at once; a following MUL 3x4 -> 12 with normal latency.
